ps2_scan_receiver: RTL and testbench
====================================

Name: ps2_scan_receiver

Overview:
- Upstream stage of the PS/2-to-ASCII keyboard converter. Receives raw PS/2 device-to-host frames on PS2_KBCLK/PS2_KBDAT.
- Strips set-2 prefixes (E0 extended, F0 break, E1 pause sequence) and presents each key event as level outputs RX_SCAN/RX_PRESSED/RX_EXTENDED, plus a one-cycle strobe.
- The consumer decodes those levels every KB_CLK cycle, so outputs hold between events.

Parameters:
- FILTER_LEN, 8: KB_CLK samples that must agree before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 4096: KB_CLK cycles without a falling edge, mid-frame, before the frame is aborted.
- PAUSE_SWALLOW, 7: bytes discarded after an E1 prefix.

Ports:
- KB_CLK  in  1  block clock, also used for all sampling.
- RESET  in  1  asynchronous, active-high reset.
- PS2_KBCLK  in  1  raw PS/2 clock line, asynchronous.
- PS2_KBDAT  in  1  raw PS/2 data line, asynchronous.
- RX_SCAN  out  8  last non-prefix scan code.
- RX_PRESSED  out  1  1 = make, 0 = break (F0 seen) for RX_SCAN.
- RX_EXTENDED  out  1  1 = E0 prefix preceded RX_SCAN.
- RX_STROBE  out  1  one-cycle pulse when RX_SCAN/RX_PRESSED/RX_EXTENDED update.
- RX_ERROR  out  1  one-cycle pulse on framing/parity/timeout error.

Behaviour:
- Reset value of every output and state register, applied immediately on RESET=1:
  - RX_SCAN=8'h00, RX_PRESSED=0, RX_EXTENDED=0, RX_STROBE=0, RX_ERROR=0.
  - Frame FSM in IDLE; prefix flags and pause counter cleared; filtered clock = 1.
- Input conditioning:
  - Both lines pass through a 2-FF synchronizer.
  - The clock then goes through a FILTER_LEN-deep shift; the filtered clock goes 0 only when all samples are 0, and 1 only when all are 1.
  - Falling edge = filtered clock 1->0. Data is sampled from the synchronized data line in that cycle.
- Frame FSM (advances only on falling edges):
  - IDLE: data bit 0 -> DATA, bit count=0. Data bit 1 (bad start bit) -> stay IDLE, no error.
  - DATA: shift LSB first. After 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: stop bit must be 1 and the 9 bits (data+parity) must have odd weight.
    - Pass -> byte valid; go to IDLE.
    - Fail -> RX_ERROR pulse; clear prefix flags; go to IDLE.
- Timeout: in any state other than IDLE, TIMEOUT_CYCLES consecutive cycles with no falling edge -> IDLE, RX_ERROR pulse, prefix flags cleared. The counter resets on every falling edge.
- Byte handling, in the cycle after the STOP edge, first match wins:
  - Pause counter nonzero: decrement, discard byte.
  - E1: pause counter = PAUSE_SWALLOW, discard.
  - E0: ext flag = 1.
  - F0: brk flag = 1.
  - AA, FA, EE, FE, 00, FF: discard; flags unchanged.
  - Otherwise:
    - RX_SCAN <= byte, RX_PRESSED <= ~brk, RX_EXTENDED <= ext.
    - RX_STROBE = 1 for one cycle.
    - Clear both flags.
- Latency: outputs update exactly 1 KB_CLK after the cycle that detects the stop-bit falling edge.
- A repeated make (typematic) of the same code still strobes; outputs are unchanged in value.
- RESET mid-frame discards the partial frame. There is no output update on reset release.
- The block is receive-only. It never drives PS/2 lines.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: the odd-parity failure in STOP raises RX_ERROR and discards the byte, as described under Behaviour.
- Undefined: the parity bit is sampled but ignored. Only the start bit, stop bit and timeout are checked.

Decomposition:
- Package ps2_pkg holds:
  - prefix constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1;
  - the device-response ignore list;
  - the frame-state enum IDLE/DATA/PARITY/STOP.
- Sub-module ps2_line_filter contains the synchronizer plus glitch filter and outputs the filtered clock, falling-edge pulse and synced data.
- ps2_scan_receiver contains the frame FSM, timeout counter and prefix logic.

Test Plan:
- Frame 1C, valid parity, 12 kHz PS/2 clock -> single RX_STROBE; RX_SCAN=1C, RX_PRESSED=1, RX_EXTENDED=0.
- Sequence F0 1C -> one strobe only, after the 1C; RX_SCAN=1C, RX_PRESSED=0. No strobe after F0.
- Sequence E0 F0 75 -> RX_SCAN=75, RX_PRESSED=0, RX_EXTENDED=1. The following 75 alone gives RX_EXTENDED=0, RX_PRESSED=1.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 5A -> zero strobes during the pause bytes; one strobe with RX_SCAN=5A.
- Frame with wrong parity on byte 16 (PS2_PARITY_CHECK_EN defined) -> RX_ERROR pulse, no strobe, outputs hold their previous values. The same frame with the macro undefined -> strobe, RX_SCAN=16.
- Stop PS/2 clock after 4 data bits for TIMEOUT_CYCLES+1 cycles -> RX_ERROR pulse, FSM in IDLE. A next full frame 29 decodes correctly. A 3-cycle glitch on PS2_KBCLK (FILTER_LEN=8) -> no edge taken.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, device-response ignore list and frame states.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    // Keyboard replies (BAT ok, ACK, echo, resend, buffer errors) that carry no key event.
    function automatic logic is_device_response(input logic [7:0] code);
        case (code)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 lines into KB_CLK and glitch-filters the PS/2 clock.
// Build option: none (PS2_PARITY_CHECK_EN only affects ps2_scan_receiver).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic KB_CLK,
    input  logic RESET,
    input  logic PS2_KBCLK,
    input  logic PS2_KBDAT,
    output logic kb_clk_filt,
    output logic kb_clk_fall,
    output logic kb_dat_sync
);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] clk_hist;

    // The filtered clock only flips once the whole history agrees; the fall pulse
    // is registered together with the 1->0 change so both appear in the same cycle.
    always_ff @(posedge KB_CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync    <= 2'b11;
            dat_sync    <= 2'b11;
            clk_hist    <= '1;
            kb_clk_filt <= 1'b1;
            kb_clk_fall <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[0], PS2_KBCLK};
            dat_sync    <= {dat_sync[0], PS2_KBDAT};
            clk_hist    <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            kb_clk_fall <= 1'b0;
            if (kb_clk_filt && (clk_hist == '0)) begin
                kb_clk_filt <= 1'b0;
                kb_clk_fall <= 1'b1;
            end else if (clk_hist == '1) begin
                kb_clk_filt <= 1'b1;
            end
        end
    end

    assign kb_dat_sync = dat_sync[1];

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver that strips E0/F0/E1 prefixes into level key events.
// Build option: define PS2_PARITY_CHECK_EN to turn odd-parity failures into RX_ERROR.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PAUSE_SWALLOW  = 7
) (
    input  logic       KB_CLK,
    input  logic       RESET,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic [7:0] RX_SCAN,
    output logic       RX_PRESSED,
    output logic       RX_EXTENDED,
    output logic       RX_STROBE,
    output logic       RX_ERROR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PAUSE_SWALLOW + 1);

    logic          kb_clk_filt;
    logic          kb_clk_fall;
    logic          kb_dat;
    logic          edge_take;
    logic          parity_ok;

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] timeout_cnt;
    logic          byte_valid;
    logic          ext_flag;
    logic          brk_flag;
    logic [PW-1:0] pause_cnt;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .KB_CLK      (KB_CLK),
        .RESET       (RESET),
        .PS2_KBCLK   (PS2_KBCLK),
        .PS2_KBDAT   (PS2_KBDAT),
        .kb_clk_filt (kb_clk_filt),
        .kb_clk_fall (kb_clk_fall),
        .kb_dat_sync (kb_dat)
    );

    assign edge_take = kb_clk_fall & ~kb_clk_filt;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    assign parity_ok = ^{shreg, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Frame FSM, timeout watchdog and prefix tracking share one register block so
    // flag clearing on errors and on completed key events has a single owner.
    always_ff @(posedge KB_CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            timeout_cnt <= '0;
            byte_valid  <= 1'b0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            pause_cnt   <= '0;
            RX_SCAN     <= 8'h00;
            RX_PRESSED  <= 1'b0;
            RX_EXTENDED <= 1'b0;
            RX_STROBE   <= 1'b0;
            RX_ERROR    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            RX_STROBE  <= 1'b0;
            RX_ERROR   <= 1'b0;

            if ((state == IDLE) || edge_take) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end

            if (edge_take) begin
                case (state)
                    IDLE: begin
                        if (!kb_dat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= {kb_dat, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= kb_dat;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (kb_dat && parity_ok) begin
                            byte_valid <= 1'b1;
                        end else begin
                            RX_ERROR <= 1'b1;
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if ((state != IDLE) && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                state    <= IDLE;
                RX_ERROR <= 1'b1;
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end

            // shreg still holds the completed byte here; the next start bit is far away.
            if (byte_valid) begin
                if (pause_cnt != '0) begin
                    pause_cnt <= pause_cnt - PW'(1);
                end else if (shreg == PS2_PFX_PAUSE) begin
                    pause_cnt <= PW'(PAUSE_SWALLOW);
                end else if (shreg == PS2_PFX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shreg == PS2_PFX_BRK) begin
                    brk_flag <= 1'b1;
                end else if (!is_device_response(shreg)) begin
                    RX_SCAN     <= shreg;
                    RX_PRESSED  <= ~brk_flag;
                    RX_EXTENDED <= ext_flag;
                    RX_STROBE   <= 1'b1;
                    ext_flag    <= 1'b0;
                    brk_flag    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: table of key bytes plus timeout, glitch and reset cases.
// Build option: expectations for the bad-parity row follow PS2_PARITY_CHECK_EN.
module tb_ps2_scan_receiver;

    localparam int HALF           = 20;
    localparam int GAP            = 60;
    localparam int TIMEOUT_CYCLES = 4096;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        int         exp_strobes;
        int         exp_errors;
        logic [7:0] exp_scan;
        logic       exp_pressed;
        logic       exp_ext;
    } vec_t;

    logic       kb_clk = 1'b0;
    logic       reset  = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] rx_scan;
    logic       rx_pressed;
    logic       rx_extended;
    logic       rx_strobe;
    logic       rx_error;

    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   err_cnt = 0;
    vec_t vecs[$];

    ps2_scan_receiver #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PAUSE_SWALLOW  (7)
    ) dut (
        .KB_CLK      (kb_clk),
        .RESET       (reset),
        .PS2_KBCLK   (ps2_clk),
        .PS2_KBDAT   (ps2_dat),
        .RX_SCAN     (rx_scan),
        .RX_PRESSED  (rx_pressed),
        .RX_EXTENDED (rx_extended),
        .RX_STROBE   (rx_strobe),
        .RX_ERROR    (rx_error)
    );

    always #5 kb_clk = ~kb_clk;

    always @(negedge kb_clk) begin
        if (!reset) begin
            if (rx_strobe) strobe_cnt = strobe_cnt + 1;
            if (rx_error)  err_cnt    = err_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] code, input logic bad_par, input int strobes,
                           input int errs, input logic [7:0] scan, input logic pressed,
                           input logic ext);
        vec_t v;
        v.code        = code;
        v.bad_par     = bad_par;
        v.exp_strobes = strobes;
        v.exp_errors  = errs;
        v.exp_scan    = scan;
        v.exp_pressed = pressed;
        v.exp_ext     = ext;
        vecs.push_back(v);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge kb_clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge kb_clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] code, input logic bad_par);
        logic p;
        p = ~(^code) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(p);
        send_bit(1'b1);
        repeat (GAP) @(negedge kb_clk);
    endtask

    task automatic check_event(input string tag, input int s0, input int e0, input int strobes,
                               input int errs, input logic [7:0] scan, input logic pressed,
                               input logic ext);
        check_output({tag, " strobes"}, strobe_cnt - s0, strobes);
        check_output({tag, " errors"},  err_cnt - e0, errs);
        check_output({tag, " scan"},    rx_scan, scan);
        check_output({tag, " pressed"}, rx_pressed, pressed);
        check_output({tag, " ext"},     rx_extended, ext);
    endtask

    initial begin
        int s0;
        int e0;

        add_vec(8'h1C, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0);
        add_vec(8'hF0, 1'b0, 0, 0, 8'h1C, 1'b1, 1'b0);
        add_vec(8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0);
        add_vec(8'hE0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0);
        add_vec(8'hF0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0);
        add_vec(8'h75, 1'b0, 1, 0, 8'h75, 1'b0, 1'b1);
        add_vec(8'h75, 1'b0, 1, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'hE1, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'h14, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'h77, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'hE1, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'hF0, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'h14, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'hF0, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'h77, 1'b0, 0, 0, 8'h75, 1'b1, 1'b0);
        add_vec(8'h5A, 1'b0, 1, 0, 8'h5A, 1'b1, 1'b0);
        add_vec(8'hAA, 1'b0, 0, 0, 8'h5A, 1'b1, 1'b0);
        add_vec(8'hFA, 1'b0, 0, 0, 8'h5A, 1'b1, 1'b0);
        add_vec(8'h5A, 1'b0, 1, 0, 8'h5A, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        add_vec(8'h16, 1'b1, 0, 1, 8'h5A, 1'b1, 1'b0);
`else
        add_vec(8'h16, 1'b1, 1, 0, 8'h16, 1'b1, 1'b0);
`endif
        add_vec(8'hE0, 1'b0, 0, 0, 8'h16 ^ 8'h00, 1'b1, 1'b0);
        add_vec(8'hFA, 1'b0, 0, 0, 8'h16, 1'b1, 1'b0);
        add_vec(8'h1C, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        vecs[20].exp_scan = 8'h5A;
        vecs[21].exp_scan = 8'h5A;
`endif

        repeat (5) @(negedge kb_clk);
        check_output("reset scan",    rx_scan, 8'h00);
        check_output("reset pressed", rx_pressed, 1'b0);
        check_output("reset ext",     rx_extended, 1'b0);
        check_output("reset strobe",  rx_strobe, 1'b0);
        check_output("reset error",   rx_error, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge kb_clk);

        for (int i = 0; i < vecs.size(); i++) begin
            s0 = strobe_cnt;
            e0 = err_cnt;
            send_byte(vecs[i].code, vecs[i].bad_par);
            check_event($sformatf("row%0d", i), s0, e0, vecs[i].exp_strobes, vecs[i].exp_errors,
                        vecs[i].exp_scan, vecs[i].exp_pressed, vecs[i].exp_ext);
        end

        $display("[TB] timeout after partial frame");
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (TIMEOUT_CYCLES + 200) @(negedge kb_clk);
        check_event("timeout", s0, e0, 0, 1, 8'h1C, 1'b1, 1'b1);
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_byte(8'h29, 1'b0);
        check_event("after timeout", s0, e0, 1, 0, 8'h29, 1'b1, 1'b0);

        $display("[TB] short clock glitch");
        s0 = strobe_cnt;
        e0 = err_cnt;
        ps2_dat = 1'b0;
        repeat (5) @(negedge kb_clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge kb_clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge kb_clk);
        ps2_dat = 1'b1;
        repeat (30) @(negedge kb_clk);
        send_byte(8'h29, 1'b0);
        check_event("glitch", s0, e0, 1, 0, 8'h29, 1'b1, 1'b0);

        $display("[TB] reset mid-frame");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        #1;
        check_output("midreset scan",    rx_scan, 8'h00);
        check_output("midreset pressed", rx_pressed, 1'b0);
        check_output("midreset ext",     rx_extended, 1'b0);
        repeat (4) @(negedge kb_clk);
        reset   = 1'b0;
        ps2_dat = 1'b1;
        repeat (50) @(negedge kb_clk);
        check_output("post reset scan", rx_scan, 8'h00);
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_byte(8'h5A, 1'b0);
        check_event("after reset", s0, e0, 1, 0, 8'h5A, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
